// File: rtl/simplecpu_out_capture_if.sv
// Wishbone slave bus between the management core and the out_port capture block.
// Single-cycle registered ack, no wait states, no backpressure beyond one-request-per-ack.
interface simplecpu_out_capture_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/simplecpu_out_capture.sv
// Timestamps every change of the simplecpu out_port into a FIFO drained over Wishbone.
// Ack one cycle after request; a full FIFO drops new changes and sets sticky overflow.
module simplecpu_out_capture #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    simplecpu_out_capture_if.slave wbs,
    input  logic [DATA_W-1:0]     out_port,
    output logic                  irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_W + TS_W;
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);
    localparam logic [TS_W-1:0] TS_ONE   = TS_W'(1);

    logic [TS_W-1:0]   r_ts;
    logic [DATA_W-1:0] r_prev;
    logic              r_en;
    logic              r_irq_en;
    logic              r_ovf;
    logic              r_ack;
    logic [31:0]       r_dat;
    logic              r_irq;
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [EW-1:0]     r_mem [DEPTH];

    logic              w_req;
    logic              w_rd;
    logic              w_ctrl_wr;
    logic              w_clear;
    logic              w_push;
    logic              w_pop;
    logic              w_store;
    logic              w_empty;
    logic              w_full;
    logic [1:0]        w_adr;
    logic [EW-1:0]     w_head;
    logic [31:0]       w_rdata;
    logic              w_unused;

    assign w_adr     = wbs.wbs_adr_i[3:2];
    assign w_req     = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~r_ack;
    assign w_rd      = w_req & ~wbs.wbs_we_i;
    assign w_ctrl_wr = w_req & wbs.wbs_we_i & (w_adr == 2'd2) & wbs.wbs_sel_i[0];
    assign w_clear   = w_ctrl_wr & wbs.wbs_dat_i[2];
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_FULL);
    assign w_push    = r_en & (out_port != r_prev);
    assign w_pop     = w_rd & (w_adr == 2'd1) & ~w_empty;
    // A pop frees the slot this cycle, so a push into a full FIFO still lands.
    assign w_store   = w_push & ~w_clear & (~w_full | w_pop);
    assign w_head    = r_mem[r_rptr];
    assign w_unused  = &{1'b0, wbs.wbs_adr_i[31:4], wbs.wbs_adr_i[1:0],
                         wbs.wbs_sel_i[3:1], wbs.wbs_dat_i[31:3]};

    always_comb begin
        w_rdata = '0;
        case (w_adr)
            2'd0: begin
                w_rdata[CW-1:0] = r_count;
                w_rdata[16]     = w_empty;
                w_rdata[17]     = w_full;
                w_rdata[18]     = r_ovf;
            end
            2'd1: begin
                if (!w_empty) begin
                    w_rdata[EW-1:0] = w_head;
                end
            end
            2'd2: begin
                w_rdata[0] = r_en;
                w_rdata[1] = r_irq_en;
            end
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wptr] <= {r_ts, out_port};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ts     <= '0;
            r_prev   <= '0;
            r_en     <= 1'b0;
            r_irq_en <= 1'b0;
            r_ovf    <= 1'b0;
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_irq    <= 1'b0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
        end else begin
            r_ts   <= r_ts + TS_ONE;
            r_prev <= out_port;
            r_ack  <= w_req;
            r_dat  <= w_rd ? w_rdata : 32'd0;
            r_irq  <= r_irq_en & (~w_empty | r_ovf);
            if (w_ctrl_wr) begin
                r_en     <= wbs.wbs_dat_i[0];
                r_irq_en <= wbs.wbs_dat_i[1];
            end
            if (w_clear) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else begin
                if (w_store) begin
                    r_wptr <= r_wptr + PTR_ONE;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PTR_ONE;
                end
                if (w_store && !w_pop) begin
                    r_count <= r_count + CNT_ONE;
                end else if (!w_store && w_pop) begin
                    r_count <= r_count - CNT_ONE;
                end
                if (w_push && w_full && !w_pop) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_dat;
    assign irq           = r_irq;
endmodule

// File: tb/tb_simplecpu_out_capture.sv
// Scoreboarded bench for simplecpu_out_capture: bus reads queue expected data, a monitor checks on ack.
module tb_simplecpu_out_capture;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] out_port = 8'h00;
    logic       irq;

    simplecpu_out_capture_if bus();

    simplecpu_out_capture #(.DATA_W(8), .DEPTH(16), .TS_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .wbs      (bus.slave),
        .out_port (out_port),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Reference cycle counter: the timestamp the capture block should be holding.
    logic [15:0] tb_ts;
    always @(posedge clk or posedge reset) begin
        if (reset) tb_ts <= 16'd0;
        else       tb_ts <= tb_ts + 16'd1;
    end

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q [$];
    bit          chk_q [$];
    string       name_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    logic [31:0] m_exp;
    bit          m_chk;
    string       m_name;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.wbs_ack_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack: got ack with data 0x%08h, required no ack", bus.wbs_dat_o);
                end else begin
                    m_exp  = exp_q.pop_front();
                    m_chk  = chk_q.pop_front();
                    m_name = name_q.pop_front();
                    if (m_chk) check(m_name, bus.wbs_dat_o, m_exp);
                end
            end else begin
                check("dat_idle_zero", bus.wbs_dat_o, 32'd0);
            end
        end
    end

    task automatic idle_bus();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_dat_i = 32'd0;
        bus.wbs_adr_i = 32'd0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic xfer(input bit we, input logic [1:0] a, input logic [31:0] d,
                        input logic [3:0] sel, input logic [31:0] exp, input string name,
                        input bit do_chg, input logic [7:0] chg_val);
        int n;
        exp_q.push_back(exp);
        chk_q.push_back(!we);
        name_q.push_back(name);
        @(posedge clk);
        #1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = sel;
        bus.wbs_dat_i = d;
        bus.wbs_adr_i = {28'h0, a, 2'b00};
        if (do_chg) out_port = chg_val;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.wbs_ack_o && n < 4);
        idle_bus();
        if (!bus.wbs_ack_o) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout %s: got no ack in %0d cycles, required ack after 1", name, n);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        xfer(1'b0, a, 32'd0, 4'h0, exp, name, 1'b0, 8'h00);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] sel);
        xfer(1'b1, a, d, sel, 32'd0, "write", 1'b0, 8'h00);
    endtask

    task automatic chg(input logic [7:0] v, output logic [15:0] ts);
        @(posedge clk);
        #1;
        out_port = v;
        ts = tb_ts;
    endtask

    function automatic logic [31:0] entry(input logic [15:0] ts, input logic [7:0] d);
        return {8'h00, ts, d};
    endfunction

    initial begin
        logic [15:0] ts0, ts1, tsf, tsr, ts5, tdummy;
        int acks, dbl;
        bit prev_ack;

        idle_bus();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
        check("reset_dat", bus.wbs_dat_o, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd(2'd0, 32'h0001_0000, "reset_status");
        rd(2'd2, 32'h0000_0000, "reset_ctrl");

        // Two changes three cycles apart, then drain.
        wr(2'd2, 32'h1, 4'h1);
        chg(8'h12, ts0);
        cycles(2);
        chg(8'h34, ts1);
        check("ts_spacing", {16'd0, ts1}, {16'd0, ts0 + 16'd3});
        cycles(2);
        rd(2'd0, 32'h0000_0002, "t1_status_count2");
        rd(2'd1, entry(ts0, 8'h12), "t1_data0");
        rd(2'd1, entry(ts0 + 16'd3, 8'h34), "t1_data1");
        rd(2'd1, 32'h0, "t1_data_empty");
        rd(2'd0, 32'h0001_0000, "t1_status_empty");

        // Constant port, then toggles with capture disabled, then re-enable without a change.
        cycles(50);
        rd(2'd0, 32'h0001_0000, "t2_const");
        wr(2'd2, 32'h0, 4'h1);
        chg(8'h55, tdummy);
        chg(8'hAA, tdummy);
        chg(8'h5A, tdummy);
        cycles(2);
        rd(2'd0, 32'h0001_0000, "t2_disabled");
        wr(2'd2, 32'h1, 4'h1);
        cycles(3);
        rd(2'd0, 32'h0001_0000, "t2_enable_no_push");

        // Seventeen changes into a 16-deep FIFO.
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk);
            #1;
            out_port = 8'h40 + 8'(i);
            if (i == 1) tsf = tb_ts;
        end
        cycles(2);
        rd(2'd0, 32'h0006_0010, "t3_full_ovf");
        rd(2'd1, entry(tsf, 8'h41), "t3_first_entry");
        rd(2'd0, 32'h0004_000F, "t3_after_pop");
        wr(2'd2, 32'h5, 4'h1);
        rd(2'd0, 32'h0001_0000, "t3_cleared");

        // Refill to exactly full, then pop while a new change arrives.
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            out_port = 8'h60 + 8'(i);
            if (i == 1) tsr = tb_ts;
        end
        cycles(2);
        rd(2'd0, 32'h0002_0010, "t4_full_no_ovf");
        xfer(1'b0, 2'd1, 32'd0, 4'h0, entry(tsr, 8'h61), "t4_pop_with_push", 1'b1, 8'h99);
        cycles(1);
        rd(2'd0, 32'h0002_0010, "t4_still_full");
        rd(2'd1, entry(tsr + 16'd1, 8'h62), "t4_second_entry");
        rd(2'd0, 32'h0000_000F, "t4_count15");

        // Interrupt on non-empty and on overflow, cleared by CTRL clear.
        wr(2'd2, 32'h7, 4'h1);
        cycles(2);
        check("t5_irq_idle", {31'd0, irq}, 32'd0);
        chg(8'h11, ts5);
        cycles(3);
        check("t5_irq_one_entry", {31'd0, irq}, 32'd1);
        rd(2'd1, entry(ts5, 8'h11), "t5_pop");
        cycles(2);
        check("t5_irq_after_pop", {31'd0, irq}, 32'd0);
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk);
            #1;
            out_port = 8'h20 + 8'(i);
        end
        cycles(3);
        check("t5_irq_overflow", {31'd0, irq}, 32'd1);
        rd(2'd0, 32'h0006_0010, "t5_status_ovf");
        check("t5_irq_held", {31'd0, irq}, 32'd1);
        wr(2'd2, 32'h7, 4'h1);
        cycles(2);
        check("t5_irq_cleared", {31'd0, irq}, 32'd0);
        rd(2'd0, 32'h0001_0000, "t5_status_cleared");

        // Strobe held for six cycles on STATUS.
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'h0001_0000);
            chk_q.push_back(1'b1);
            name_q.push_back("t6_held_status");
        end
        @(posedge clk);
        #1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_adr_i = 32'h0;
        acks = 0;
        dbl = 0;
        prev_ack = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.wbs_ack_o) acks++;
            if (bus.wbs_ack_o && prev_ack) dbl++;
            prev_ack = bus.wbs_ack_o;
        end
        idle_bus();
        check("t6_ack_count", acks, 32'd3);
        check("t6_back_to_back_acks", dbl, 32'd0);

        wr(2'd2, 32'h0, 4'h0);
        rd(2'd2, 32'h0000_0003, "t6_ctrl_sel0_kept");
        wr(2'd0, 32'hFFFF_FFFF, 4'hF);
        wr(2'd1, 32'hFFFF_FFFF, 4'hF);
        rd(2'd0, 32'h0001_0000, "t6_status_writes_ignored");
        rd(2'd3, 32'h0, "t6_reg3");

        cycles(3);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending responses, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/simplecpu_out_capture.md
Name: simplecpu_out_capture

Overview:
- Reader side of the simplecpu output port: watches `out_port` every clock and records each value change with a 16-bit cycle timestamp in a FIFO.
- Management firmware drains the FIFO over the Wishbone slave bus, beside the simplecpu instance in the user project wrapper.
- Gives firmware a lossless, timestamped trace of what the CPU program writes to its output port. This replaces sampling the IO pins.

Parameters:
- DATA_W, 8, width of the observed `out_port`.
- DEPTH, 16, FIFO entries; must be a power of two, minimum 2.
- TS_W, 16, timestamp counter width; DATA_W + TS_W ≤ 32.

Ports:
- clk  in  1  system clock (`wb_clk_i` in the wrapper).
- reset  in  1  asynchronous, active-high reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_sel_i  in  4  Wishbone byte selects.
- wbs_dat_i  in  32  Wishbone write data.
- wbs_adr_i  in  32  Wishbone address; only bits [3:2] are decoded, and upper decode is done by the wrapper.
- wbs_ack_o  out  1  Wishbone acknowledge.
- wbs_dat_o  out  32  Wishbone read data.
- out_port  in  DATA_W  simplecpu output port being observed.
- irq  out  1  level interrupt.

Behaviour:
- Decision: one clock; reset is asynchronous and active-high. The ports are named `clk` and `reset`, as on simplecpu.
- Reset values: all outputs 0; FIFO empty; `prev` = 0; timestamp = 0; CTRL = 0; overflow = 0.
- Timestamp:
  - TS_W-bit free-running counter, +1 every cycle.
  - Wraps from all-ones to 0.
- Change detect:
  - `prev` <= `out_port` every cycle, whether or not capture is enabled.
  - A push is requested when CTRL.en = 1 and `out_port` != `prev`.
  - The entry is {timestamp, `out_port`}, with timestamp taken in the same cycle the difference is seen.
  - Enabling capture does not create a push unless the port actually changes.
- Register map (`wbs_adr_i[3:2]`):
  - 0 STATUS (RO):
    - [clog2(DEPTH):0] count
    - [16] empty
    - [17] full
    - [18] overflow
    - other bits 0
  - 1 DATA (RO, pop on read):
    - [DATA_W-1:0] data
    - [DATA_W+TS_W-1:DATA_W] timestamp
    - other bits 0
    - Reading DATA while empty returns 0 and changes nothing.
  - 2 CTRL (RW):
    - [0] en
    - [1] irq_en
    - [2] clear, write-1 self-clearing, reads 0
    - Written only when `wbs_sel_i[0]` = 1.
  - 3: reads 0, writes ignored.
  - Writes to STATUS and DATA are acked and ignored.
- Wishbone handshake:
  - Request = `wbs_cyc_i` & `wbs_stb_i` & !`wbs_ack_o`.
  - `wbs_ack_o` asserts exactly one cycle after a request and stays high for one cycle.
  - `wbs_dat_o` is registered and valid only while ack is high; it is 0 otherwise.
  - A held strobe gives acks on alternate cycles.
  - CTRL write and FIFO pop take effect at the ack edge.
  - Read data reflects state as of the request cycle.
- FIFO:
  - Circular buffer with read/write pointers that wrap at DEPTH.
  - Count runs 0..DEPTH.
  - Push while full and no pop in the same cycle: the entry is dropped and overflow is set (sticky).
  - Push and pop in the same cycle while full: both happen, count is unchanged, no overflow.
  - Push and pop in the same cycle while empty: the pop returns 0, the push is stored, count = 1.
- Clear (CTRL[2] = 1):
  - Empties the FIFO and resets the pointers.
  - Clears overflow.
  - A push in the same cycle is discarded.
  - The en and irq_en bits take the written values.
- irq: registered, = irq_en & (!empty | overflow).
- Reset mid-transaction: ack drops immediately, and FIFO contents are lost.

Test Plan:
1. Reset, write CTRL = 0x1; drive `out_port` 0x00→0x12 at cycle T, then 0x34 at T+3 → STATUS.count = 2. DATA reads return data 0x12 with timestamp ts0, then data 0x34 with timestamp ts0+3, then 0 with count 0.
2. `out_port` held constant for 50 cycles with en = 1 → count stays 0. Toggle with en = 0 → count stays 0.
3. Produce 17 changes with DEPTH = 16 → STATUS shows full = 1, overflow = 1, count = 16. The first entry read holds the first value.
4. With the FIFO full, a DATA read coincides with a new change → count stays 16 and overflow stays 0.
5. With irq_en = 1 and one entry: irq = 1 → pop it → irq = 0. Then cause an overflow → irq = 1 until CTRL write 0x7 (clear), after which irq = 0 and count = 0.
6. Hold `wbs_stb_i`/`wbs_cyc_i` high on a STATUS read for 6 cycles → exactly 3 single-cycle acks. Writing CTRL with `wbs_sel_i` = 0 leaves CTRL unchanged.
